// File: rtl/l2_state_arb_pkg.sv
// L2 state-array arbiter: shared defaults and encodings.
package l2_state_arb_pkg;

  localparam int DEF_INDEX_W      = 8;
  localparam int DEF_DATA_W       = 66;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam logic SEL_PIPE1 = 1'b0;
  localparam logic SEL_PIPE2 = 1'b1;

endpackage

// File: rtl/l2_state_bypass.sv
// One-cycle write record and read-data merge for the L2 state array.
module l2_state_bypass
  import l2_state_arb_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] idx,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  wmask,
  input  logic [DATA_W-1:0]  arr_rdata,
  output logic [DATA_W-1:0]  rsp_data
);

  logic               wr_vld_d, wr_vld_q;
  logic [INDEX_W-1:0] wr_idx_d, wr_idx_q;
  logic [DATA_W-1:0]  wr_data_d, wr_data_q;
  logic [DATA_W-1:0]  wr_mask_d, wr_mask_q;
  logic               hit_d, hit_q;
  logic [DATA_W-1:0]  hit_data_d, hit_data_q;
  logic [DATA_W-1:0]  hit_mask_d, hit_mask_q;

  always_comb begin
    wr_vld_d   = wr_en;
    wr_idx_d   = wr_en ? idx   : wr_idx_q;
    wr_data_d  = wr_en ? wdata : wr_data_q;
    wr_mask_d  = wr_en ? wmask : wr_mask_q;
    // A read sees last cycle's write only; the array has not committed it yet
    hit_d      = rd_en && wr_vld_q && (wr_idx_q == idx);
    hit_data_d = rd_en ? wr_data_q : hit_data_q;
    hit_mask_d = rd_en ? wr_mask_q : hit_mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      wr_vld_q <= wr_vld_d;
      hit_q    <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_idx_q   <= wr_idx_d;
    wr_data_q  <= wr_data_d;
    wr_mask_q  <= wr_mask_d;
    hit_data_q <= hit_data_d;
    hit_mask_q <= hit_mask_d;
  end

  always_comb begin
    rsp_data = arr_rdata;
    if (hit_q)
      rsp_data = (hit_data_q & hit_mask_q)
               | (arr_rdata & ~hit_mask_q);
  end

endmodule

// File: rtl/l2_state_arb.sv
// Two-pipe arbiter for the L2 state array with pipe1 starvation guard
// and write-to-read bypass on the response path.
module l2_state_arb
  import l2_state_arb_pkg::*;
#(
  parameter int INDEX_W      = DEF_INDEX_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1_req_val,
  input  logic               p1_req_we,
  input  logic [INDEX_W-1:0] p1_req_idx,
  input  logic [DATA_W-1:0]  p1_req_data,
  input  logic [DATA_W-1:0]  p1_req_mask,
  output logic               p1_req_rdy,
  input  logic               p2_req_val,
  input  logic               p2_req_we,
  input  logic [INDEX_W-1:0] p2_req_idx,
  input  logic [DATA_W-1:0]  p2_req_data,
  input  logic [DATA_W-1:0]  p2_req_mask,
  output logic               p2_req_rdy,
  output logic               arr_en,
  output logic               arr_we,
  output logic [INDEX_W-1:0] arr_idx,
  output logic [DATA_W-1:0]  arr_data,
  output logic [DATA_W-1:0]  arr_mask,
  input  logic [DATA_W-1:0]  arr_rdata,
  output logic               rsp_val,
  output logic               rsp_sel,
  output logic [DATA_W-1:0]  rsp_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  logic             pend_d, pend_q;
  logic             sel_d, sel_q;
  logic             at_limit, p1_win, p2_win, grant;
  logic             wr_en, rd_en;

  always_comb begin
    at_limit   = (starve_cnt_q == CNT_MAX);
    p1_win     = !rst && p1_req_val && (!p2_req_val || at_limit);
    p2_win     = !rst && p2_req_val && !(p1_req_val && at_limit);
    grant      = p1_win | p2_win;
    p1_req_rdy = p1_win;
    p2_req_rdy = p2_win;
    arr_en     = grant;
    arr_we     = 1'b0;
    arr_idx    = p1_req_idx;
    arr_data   = p1_req_data;
    arr_mask   = p1_req_mask;
    unique case (1'b1)
      p1_win: arr_we = p1_req_we;
      p2_win: begin
        arr_we   = p2_req_we;
        arr_idx  = p2_req_idx;
        arr_data = p2_req_data;
        arr_mask = p2_req_mask;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p1_req_val || p1_win)
      starve_cnt_d = '0;
    else if (!at_limit)
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    wr_en  = grant & arr_we;
    rd_en  = grant & ~arr_we;
    pend_d = rd_en;
    sel_d  = p2_win ? SEL_PIPE2 : SEL_PIPE1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      pend_q       <= 1'b0;
      sel_q        <= SEL_PIPE1;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pend_q       <= pend_d;
      sel_q        <= sel_d;
    end
  end

  // A read granted just before reset must not answer during reset
  assign rsp_val = pend_q & ~rst;
  assign rsp_sel = sel_q;

  l2_state_bypass #(
    .INDEX_W (INDEX_W),
    .DATA_W  (DATA_W)
  ) u_bypass (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .idx       (arr_idx),
    .wdata     (arr_data),
    .wmask     (arr_mask),
    .arr_rdata (arr_rdata),
    .rsp_data  (rsp_data)
  );

endmodule

// File: tb/tb_l2_state_arb.sv
// Randomized bench for l2_state_arb against a memory-level model
// (instant-write shadow array vs. one-cycle-late physical array).
module tb_l2_state_arb;

  localparam int IW = 8;
  localparam int DW = 66;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p1_req_val, p1_req_we;
  logic [IW-1:0] p1_req_idx;
  logic [DW-1:0] p1_req_data, p1_req_mask;
  logic          p1_req_rdy;
  logic          p2_req_val, p2_req_we;
  logic [IW-1:0] p2_req_idx;
  logic [DW-1:0] p2_req_data, p2_req_mask;
  logic          p2_req_rdy;
  logic          arr_en, arr_we;
  logic [IW-1:0] arr_idx;
  logic [DW-1:0] arr_data, arr_mask, arr_rdata;
  logic          rsp_val, rsp_sel;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  l2_state_arb #(
    .INDEX_W      (IW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p1_req_val  (p1_req_val),
    .p1_req_we   (p1_req_we),
    .p1_req_idx  (p1_req_idx),
    .p1_req_data (p1_req_data),
    .p1_req_mask (p1_req_mask),
    .p1_req_rdy  (p1_req_rdy),
    .p2_req_val  (p2_req_val),
    .p2_req_we   (p2_req_we),
    .p2_req_idx  (p2_req_idx),
    .p2_req_data (p2_req_data),
    .p2_req_mask (p2_req_mask),
    .p2_req_rdy  (p2_req_rdy),
    .arr_en      (arr_en),
    .arr_we      (arr_we),
    .arr_idx     (arr_idx),
    .arr_data    (arr_data),
    .arr_mask    (arr_mask),
    .arr_rdata   (arr_rdata),
    .rsp_val     (rsp_val),
    .rsp_sel     (rsp_sel),
    .rsp_data    (rsp_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model state
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] phys   [256];
  int            starve;
  bit            pend, pend_sel;
  logic [DW-1:0] pend_exp, rd_next;
  bit            dw_v;
  int            dw_idx;
  logic [DW-1:0] dw_d, dw_m;
  logic          last_g1, last_we, last_rv, last_sel;
  logic [DW-1:0] last_rsp;

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic idle_in();
    p1_req_val = 1'b0; p1_req_we = 1'b0;
    p2_req_val = 1'b0; p2_req_we = 1'b0;
  endtask

  task automatic step();
    bit g1, g2, w;
    int idx;
    logic [DW-1:0] d, m;
    arr_rdata = pend ? rd_next : rnd();
    g1 = !rst && p1_req_val && (!p2_req_val || starve == SL);
    g2 = !rst && p2_req_val && !g1;
    w  = g1 ? p1_req_we : (g2 ? p2_req_we : 1'b0);
    idx  = g1 ? int'(p1_req_idx) : int'(p2_req_idx);
    d    = g1 ? p1_req_data : p2_req_data;
    m    = g1 ? p1_req_mask : p2_req_mask;
    @(negedge clk);
    chk("p1_rdy", DW'(p1_req_rdy), DW'(g1));
    chk("p2_rdy", DW'(p2_req_rdy), DW'(g2));
    chk("arr_en", DW'(arr_en), DW'(g1 | g2));
    chk("arr_we", DW'(arr_we), DW'(w));
    if (g1 | g2) begin
      chk("arr_idx", DW'(arr_idx), DW'(idx));
      chk("arr_data", arr_data, d);
      chk("arr_mask", arr_mask, m);
    end
    chk("rsp_val", DW'(rsp_val), DW'(pend && !rst));
    if (pend && !rst) begin
      chk("rsp_sel", DW'(rsp_sel), DW'(pend_sel));
      chk("rsp_data", rsp_data, pend_exp);
    end
    last_g1 = p1_req_rdy; last_we = arr_we;
    last_rv = rsp_val; last_sel = rsp_sel; last_rsp = rsp_data;
    @(posedge clk);
    pend = 0;
    if (rst) begin
      starve = 0;
    end else begin
      if (!p1_req_val || g1) starve = 0;
      else if (starve < SL) starve++;
      if ((g1 | g2) && w)
        shadow[idx] = (d & m) | (shadow[idx] & ~m);
      else if (g1 | g2) begin
        pend = 1; pend_sel = g2;
        pend_exp = shadow[idx];
        rd_next  = phys[idx];
      end
    end
    if (dw_v) phys[dw_idx] = (dw_d & dw_m) | (phys[dw_idx] & ~dw_m);
    dw_v = (g1 | g2) && w; dw_idx = idx; dw_d = d; dw_m = m;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      shadow[i] = '0; phys[i] = '0;
    end
    shadow[6] = DW'(16'h1234); phys[6] = DW'(16'h1234);
    starve = 0; pend = 0; dw_v = 0;
    pend_exp = '0; rd_next = '0;
    p1_req_idx = '0; p1_req_data = '0; p1_req_mask = '0;
    p2_req_idx = '0; p2_req_data = '0; p2_req_mask = '0;
    idle_in();
    rst = 1'b1;
    @(posedge clk); #1;
    step(); step();
    chk("rst_starve", DW'(dut.starve_cnt_q), '0);
    rst = 1'b0;

    // contention pattern p2 x4 then p1
    p1_req_val = 1; p1_req_idx = 8'd1;
    p2_req_val = 1; p2_req_idx = 8'd2;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("pattern", DW'(last_g1), DW'(k % 5 == 4));
      if (k > 0)
        chk("pat_sel", DW'(last_sel), DW'((k - 1) % 5 != 4));
    end
    idle_in(); step(); step();

    // bypass hit
    p1_req_val = 1; p1_req_we = 1; p1_req_idx = 8'd5;
    p1_req_data = '1; p1_req_mask = 66'h3_0000_0000_0000_00FF;
    step();
    idle_in(); p2_req_val = 1; p2_req_idx = 8'd5;
    step();
    idle_in(); step();
    chk("byp_data", last_rsp, 66'h3_0000_0000_0000_00FF);
    chk("byp_sel", DW'(last_sel), DW'(1'b1));

    // no merge on different index
    p1_req_val = 1; p1_req_we = 1; p1_req_idx = 8'd5;
    step();
    idle_in(); p2_req_val = 1; p2_req_idx = 8'd6;
    step();
    idle_in(); step();
    chk("nomrg_data", last_rsp, DW'(16'h1234));

    // lone write: granted, no response
    p1_req_val = 1; p1_req_we = 1; p1_req_idx = 8'd9;
    p1_req_data = rnd(); p1_req_mask = rnd();
    step();
    chk("wr_rdy", DW'(last_g1), DW'(1'b1));
    chk("wr_we", DW'(last_we), DW'(1'b1));
    idle_in();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wr_norsp", DW'(last_rv), '0);
    end

    // read then reset
    p1_req_val = 1; p1_req_idx = 8'd3;
    step();
    idle_in(); rst = 1'b1;
    step();
    chk("rst_rsp", DW'(last_rv), '0);
    step();
    rst = 1'b0;
    step();
    chk("post_rsp", DW'(last_rv), '0);
    chk("post_starve", DW'(dut.starve_cnt_q), '0);

    // write, reset, read
    p1_req_val = 1; p1_req_we = 1; p1_req_idx = 8'd7;
    p1_req_data = rnd(); p1_req_mask = rnd();
    step();
    idle_in(); rst = 1'b1;
    step();
    rst = 1'b0; p2_req_val = 1; p2_req_idx = 8'd7;
    step();
    idle_in(); step();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 63) == 0);
      p1_req_val  = 1'($urandom_range(0, 3) != 0);
      p1_req_we   = 1'($urandom_range(0, 1));
      p1_req_idx  = IW'($urandom_range(0, 3));
      p1_req_data = rnd();
      p1_req_mask = rnd();
      p2_req_val  = 1'($urandom_range(0, 2) != 0);
      p2_req_we   = 1'($urandom_range(0, 1));
      p2_req_idx  = IW'($urandom_range(0, 3));
      p2_req_data = rnd();
      p2_req_mask = rnd();
      step();
    end
    rst = 1'b0; idle_in(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
